// File: rtl/timer_tick_scheduler.sv
// Sequences an interval-timer slave over its register bus: programs period/control, clears timeouts into ticks, snapshots the counter.
// Registered outputs; bus fields follow the state one edge after the decision. Requests outside IDLE/RUN are dropped; tmr_irq is a level.
module timer_tick_scheduler #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              snap_req,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value
);

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_WR_PL, S_WR_PH, S_WR_CTL, S_RUN,
    S_CLR, S_SNAP_W, S_SNAP_RL, S_SNAP_RH, S_SNAP_CAP
  } state_t;

  state_t      r_state;
  logic [31:0] r_period;
  logic        r_cont;
  logic        r_restart;
  logic        r_snap_run;

  state_t      w_nxt;
  logic        w_accept;
  logic        w_snap;
  logic        w_clr;
  logic        w_snap_run_nxt;
  logic        w_cs;
  logic        w_wn;
  logic [2:0]  w_addr;
  logic [15:0] w_wd;
  logic        w_in_snap;

  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_snap   = 1'b0;
    w_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_accept = 1'b1;
          w_nxt    = S_STOP;
        end else if (snap_req) begin
          w_snap = 1'b1;
          w_nxt  = S_SNAP_W;
        end
      end
      S_RUN: begin
        if (tmr_irq) begin
          w_clr = 1'b1;
          w_nxt = S_CLR;
        end else if (cfg_stop) begin
          w_nxt = S_STOP;
        end else if (cfg_start) begin
          w_accept = 1'b1;
          w_nxt    = S_STOP;
        end else if (snap_req) begin
          w_snap = 1'b1;
          w_nxt  = S_SNAP_W;
        end
      end
      S_STOP:     w_nxt = r_restart ? S_WR_PL : S_IDLE;
      S_WR_PL:    w_nxt = S_WR_PH;
      S_WR_PH:    w_nxt = S_WR_CTL;
      S_WR_CTL:   w_nxt = S_RUN;
      S_CLR:      w_nxt = r_cont ? S_RUN : S_IDLE;
      S_SNAP_W:   w_nxt = S_SNAP_RL;
      S_SNAP_RL:  w_nxt = S_SNAP_RH;
      S_SNAP_RH:  w_nxt = S_SNAP_CAP;
      S_SNAP_CAP: w_nxt = r_snap_run ? S_RUN : S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  assign w_snap_run_nxt = w_snap ? (r_state == S_RUN) : r_snap_run;
  assign w_in_snap = (w_nxt == S_SNAP_W) || (w_nxt == S_SNAP_RL) ||
                     (w_nxt == S_SNAP_RH) || (w_nxt == S_SNAP_CAP);

  // Bus fields for the state being entered; WR_* states always follow STOP, so r_period is already latched.
  always_comb begin
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_addr = 3'd0;
    w_wd   = 16'h0000;
    case (w_nxt)
      S_STOP:    begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1; w_wd = 16'h0008; end
      S_WR_PL:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd2; w_wd = r_period[15:0]; end
      S_WR_PH:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd3; w_wd = r_period[31:16]; end
      S_WR_CTL:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1; w_wd = r_cont ? 16'h0007 : 16'h0005; end
      S_CLR:     begin w_cs = 1'b1; w_wn = 1'b0; end
      S_SNAP_W:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd4; end
      S_SNAP_RL: begin w_cs = 1'b1; w_addr = 3'd4; end
      S_SNAP_RH: begin w_cs = 1'b1; w_addr = 3'd5; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_period       <= 32'h0;
      r_cont         <= 1'b0;
      r_restart      <= 1'b0;
      r_snap_run     <= 1'b0;
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'h0;
      busy           <= 1'b0;
      running        <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      snap_valid     <= 1'b0;
      snap_value     <= 32'h0;
    end else begin
      r_state        <= w_nxt;
      r_snap_run     <= w_snap_run_nxt;
      tmr_address    <= w_addr;
      tmr_chipselect <= w_cs;
      tmr_write_n    <= w_wn;
      tmr_writedata  <= w_wd;
      busy           <= (w_nxt != S_IDLE) && (w_nxt != S_RUN);
      running        <= (w_nxt == S_RUN) || (w_nxt == S_CLR) || (w_in_snap && w_snap_run_nxt);
      tick           <= w_clr;
      snap_valid     <= (r_state == S_SNAP_CAP);
      if (w_nxt == S_STOP) r_restart <= w_accept;
      if (w_accept) begin
        r_period   <= cfg_period;
        r_cont     <= cfg_continuous;
        tick_count <= '0;
      end else if (w_clr) begin
        tick_count <= tick_count + 1'b1;
      end
      // Read data lags the address by one cycle: low half lands during SNAP_RH, high half during SNAP_CAP.
      if (r_state == S_SNAP_RH)  snap_value[15:0]  <= tmr_readdata;
      if (r_state == S_SNAP_CAP) snap_value[31:16] <= tmr_readdata;
    end
  end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler with a registered-read timer slave model.
module tb_timer_tick_scheduler;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start, cfg_stop, cfg_continuous, snap_req, tmr_irq;
  logic [31:0]   cfg_period;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect, tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic [15:0]   tmr_readdata = 16'h0;
  logic          busy, running, tick, snap_valid;
  logic [TW-1:0] tick_count;
  logic [31:0]   snap_value;
  logic [31:0]   model_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt;
  int cyc;

  timer_tick_scheduler #(.TICK_W(TW)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .cfg_continuous(cfg_continuous), .snap_req(snap_req),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
    .snap_valid(snap_valid), .snap_value(snap_value)
  );

  always #5 clk = ~clk;

  // Timer slave: read data registered one cycle after the address.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? model_cnt[15:0] :
                      (tmr_address == 3'd5) ? model_cnt[31:16] : 16'h0;
    else
      tmr_readdata <= 16'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic cs, input logic wn,
                         input logic [2:0] a, input logic [15:0] d);
    check({tag, ".cs"},   32'(tmr_chipselect), 32'(cs));
    check({tag, ".wn"},   32'(tmr_write_n),    32'(wn));
    check({tag, ".addr"}, 32'(tmr_address),    32'(a));
    check({tag, ".data"}, 32'(tmr_writedata),  32'(d));
  endtask

  task automatic chk_st(input string tag, input logic b, input logic r);
    check({tag, ".busy"},    32'(busy),    32'(b));
    check({tag, ".running"}, 32'(running), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_start = 0; cfg_stop = 0; cfg_continuous = 0; snap_req = 0;
    tmr_irq = 0; cfg_period = 0; model_cnt = 0;
    repeat (2) @(negedge clk);
    chk_bus("rst", 1'b0, 1'b1, 3'd0, 16'h0);
    chk_st("rst", 1'b0, 1'b0);
    check("rst.tick_count", 32'(tick_count), 32'h0);
    check("rst.snap_value", snap_value, 32'h0);
    check("rst.tick",       32'(tick), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Program period 0x186A0, continuous
    cfg_start = 1; cfg_period = 32'h0001_86A0; cfg_continuous = 1;
    @(negedge clk); cfg_start = 0; cfg_period = 0; cfg_continuous = 0;
    chk_bus("stop", 1'b1, 1'b0, 3'd1, 16'h0008);
    chk_st("stop", 1'b1, 1'b0);
    @(negedge clk); chk_bus("wr_pl", 1'b1, 1'b0, 3'd2, 16'h86A0);
    @(negedge clk); chk_bus("wr_ph", 1'b1, 1'b0, 3'd3, 16'h0001);
    cfg_start = 1; cfg_period = 32'hDEAD_BEEF;
    @(negedge clk); cfg_start = 0; cfg_period = 0;
    chk_bus("wr_ctl", 1'b1, 1'b0, 3'd1, 16'h0007);
    @(negedge clk); chk_bus("run", 1'b0, 1'b1, 3'd0, 16'h0);
    chk_st("run", 1'b0, 1'b1);

    // Timeout service, continuous
    tmr_irq = 1;
    @(negedge clk); tmr_irq = 0;
    chk_bus("clr", 1'b1, 1'b0, 3'd0, 16'h0);
    check("clr.tick", 32'(tick), 32'h1);
    check("clr.tick_count", 32'(tick_count), 32'h1);
    chk_st("clr", 1'b1, 1'b1);
    @(negedge clk);
    check("clr_after.tick", 32'(tick), 32'h0);
    chk_st("clr_after", 1'b0, 1'b1);

    // Snapshot from RUN, irq raised mid-sequence
    model_cnt = 32'h1234_5678; snap_req = 1;
    @(negedge clk); snap_req = 0;
    chk_bus("snap_w", 1'b1, 1'b0, 3'd4, 16'h0);
    chk_st("snap_w", 1'b1, 1'b1);
    @(negedge clk); chk_bus("snap_rl", 1'b1, 1'b1, 3'd4, 16'h0);
    @(negedge clk); chk_bus("snap_rh", 1'b1, 1'b1, 3'd5, 16'h0);
    tmr_irq = 1;
    @(negedge clk); chk_bus("snap_cap", 1'b0, 1'b1, 3'd0, 16'h0);
    check("snap_cap.valid", 32'(snap_valid), 32'h0);
    @(negedge clk);
    check("snap.valid", 32'(snap_valid), 32'h1);
    check("snap.value", snap_value, 32'h1234_5678);
    chk_st("snap_ret", 1'b0, 1'b1);
    @(negedge clk); tmr_irq = 0;
    check("snap_irq.tick", 32'(tick), 32'h1);
    check("snap_irq.count", 32'(tick_count), 32'h2);
    check("snap.valid_pulse", 32'(snap_valid), 32'h0);
    @(negedge clk);

    // Priority: irq beats stop and snap, the rest are dropped
    tmr_irq = 1; cfg_stop = 1; snap_req = 1;
    @(negedge clk); tmr_irq = 0; cfg_stop = 0; snap_req = 0;
    chk_bus("pri_clr", 1'b1, 1'b0, 3'd0, 16'h0);
    check("pri.count", 32'(tick_count), 32'h3);
    @(negedge clk); chk_st("pri_run1", 1'b0, 1'b1);
    @(negedge clk); chk_st("pri_run2", 1'b0, 1'b1);

    // Stop from RUN
    cfg_stop = 1;
    @(negedge clk); cfg_stop = 0;
    chk_bus("stop_run", 1'b1, 1'b0, 3'd1, 16'h0008);
    @(negedge clk); chk_bus("stop_idle", 1'b0, 1'b1, 3'd0, 16'h0);
    chk_st("stop_idle", 1'b0, 1'b0);

    // Snapshot from IDLE; cfg_stop in IDLE is ignored
    model_cnt = 32'hCAFE_0001; snap_req = 1; cfg_stop = 1;
    @(negedge clk); snap_req = 0; cfg_stop = 0;
    chk_bus("isnap_w", 1'b1, 1'b0, 3'd4, 16'h0);
    chk_st("isnap_w", 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("isnap.valid", 32'(snap_valid), 32'h1);
    check("isnap.value", snap_value, 32'hCAFE_0001);
    chk_st("isnap_ret", 1'b0, 1'b0);

    // One-shot mode
    cfg_start = 1; cfg_period = 32'h0; cfg_continuous = 0;
    @(negedge clk); cfg_start = 0;
    check("os.count_clr", 32'(tick_count), 32'h0);
    repeat (3) @(negedge clk);
    chk_bus("os.wr_ctl", 1'b1, 1'b0, 3'd1, 16'h0005);
    @(negedge clk); chk_st("os.run", 1'b0, 1'b1);
    tmr_irq = 1;
    @(negedge clk); tmr_irq = 0;
    check("os.tick", 32'(tick), 32'h1);
    check("os.count", 32'(tick_count), 32'h1);
    @(negedge clk); chk_st("os.idle", 1'b0, 1'b0);

    // Period 0, irq held: back-to-back service up to all-ones, then wrap
    cfg_start = 1; cfg_period = 32'h0; cfg_continuous = 1;
    @(negedge clk); cfg_start = 0;
    repeat (4) @(negedge clk);
    tmr_irq = 1; exp_cnt = 0; cyc = 0;
    while (exp_cnt < 255 && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (tick) exp_cnt++;
      if (exp_cnt == 255) tmr_irq = 0;
    end
    tmr_irq = 0;
    check("b2b.ticks", 32'(exp_cnt), 32'd255);
    check("b2b.cycles", 32'(cyc), 32'd509);
    check("b2b.count", 32'(tick_count), 32'hFF);
    @(negedge clk); tmr_irq = 1;
    @(negedge clk); tmr_irq = 0;
    check("wrap.count", 32'(tick_count), 32'h0);
    check("wrap.tick", 32'(tick), 32'h1);
    @(negedge clk);

    // Reset mid-sequence during WR_PL
    cfg_start = 1; cfg_period = 32'h0002_0003; cfg_continuous = 1;
    @(negedge clk); cfg_start = 0;
    @(negedge clk); chk_bus("rs.wr_pl", 1'b1, 1'b0, 3'd2, 16'h0003);
    #2 reset = 1;
    #1 chk_bus("rs.async", 1'b0, 1'b1, 3'd0, 16'h0);
    chk_st("rs.async", 1'b0, 1'b0);
    @(negedge clk); reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rs.no_write", 32'(tmr_chipselect), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_tick_scheduler.md
TIMER_TICK_SCHEDULER -- requirements
Module: timer_tick_scheduler

Interface
REQ-001 Parameter TICK_W, default 16, width of tick_count.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cfg_start  in  1  one-cycle pulse: program and start the timer.
REQ-005 cfg_stop  in  1  one-cycle pulse: stop the timer.
REQ-006 cfg_period  in  32  period value, sampled when cfg_start is accepted.
REQ-007 cfg_continuous  in  1  continuous mode, sampled when cfg_start is accepted.
REQ-008 snap_req  in  1  one-cycle pulse: capture the timer counter.
REQ-009 tmr_address  out  3  timer slave address.
REQ-010 tmr_chipselect  out  1  timer slave select.
REQ-011 tmr_write_n  out  1  timer slave write strobe, active-low.
REQ-012 tmr_writedata  out  16  timer slave write data.
REQ-013 tmr_readdata  in  16  timer slave read data, registered: valid one cycle after the address is driven.
REQ-014 tmr_irq  in  1  timer interrupt, level.
REQ-015 busy  out  1  high in every state except IDLE and RUN.
REQ-016 running  out  1  high in RUN, and in CLR/SNAP states entered from RUN.
REQ-017 tick  out  1  one-cycle pulse per serviced timeout.
REQ-018 tick_count  out  TICK_W  serviced timeouts since the last accepted cfg_start.
REQ-019 snap_valid  out  1  one-cycle pulse; snap_value valid in the same cycle.
REQ-020 snap_value  out  32  last captured counter value.

Function
REQ-021 States SHALL be IDLE, STOP, WR_PL, WR_PH, WR_CTL, RUN, CLR, SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP.
REQ-022 Bus idle (IDLE, RUN, SNAP_CAP) SHALL be: chipselect=0, write_n=1, address=0, writedata=0.
REQ-023 Each write state SHALL issue exactly one single-cycle write (chipselect=1, write_n=0) and advance on the next edge; there is no wait state.
REQ-024 STOP: address 1, data 0x0008.
REQ-024a STOP SHALL go to WR_PL when entered via cfg_start, else to IDLE.
REQ-025 WR_PL: address 2, data period[15:0]. WR_PH: address 3, data period[31:16].
REQ-026 WR_CTL: address 1, data 0x0007 if continuous else 0x0005; next state RUN.
REQ-027 cfg_start SHALL be accepted in IDLE or RUN only (ignored when busy=1).
REQ-027a On acceptance: period and continuous latched, tick_count cleared, next state STOP.
REQ-028 In IDLE, snap_req SHALL be accepted if cfg_start is absent; cfg_stop is ignored.
REQ-029 RUN priority: tmr_irq > cfg_stop > cfg_start > snap_req.
REQ-029a Lower-priority requests in the same cycle SHALL be dropped, except tmr_irq, which is a level and is re-sampled later.
REQ-030 CLR: address 0, data 0x0000 write; tick=1 and tick_count+1 in this cycle.
REQ-030a tick_count SHALL wrap from all-ones to 0.
REQ-030b After CLR: RUN if continuous, else IDLE.
REQ-031 cfg_stop in RUN: STOP, then IDLE.
REQ-032 Snapshot sequence: SNAP_W writes address 4 data 0; SNAP_RL drives chipselect=1, write_n=1, address 4; SNAP_RH drives the same with address 5 and captures snap_value[15:0] from tmr_readdata.
REQ-032a SNAP_CAP captures snap_value[31:16], pulses snap_valid, and returns to the state the snapshot was entered from.
REQ-033 Total snapshot latency SHALL be 4 cycles from acceptance edge to snap_valid.
REQ-033a tmr_irq arriving during a snapshot SHALL be serviced on return to RUN.
REQ-034 Back-to-back period 0 SHALL be legal; the irq is then serviced every time it is seen, with no tick loss beyond what the timer itself merges.

Reset
REQ-035 reset SHALL force IDLE asynchronously.
REQ-035a Reset values: tmr_write_n=1; all other outputs, tick_count, snap_value and latched config 0.
REQ-036 Reset mid-sequence SHALL abort with no further bus writes; the timer state is not restored, and software re-issues cfg_start.

Verification
REQ-037 cfg_start, period 0x0001_86A0, continuous=1 -> writes (1,0x0008), (2,0x86A0), (3,0x0001), (1,0x0007) on 4 consecutive cycles; running=1 on the 5th.
REQ-038 In RUN, hold tmr_irq until the clear write -> write (0,0x0000), tick=1, tick_count 0->1; tmr_irq removed; state RUN; repeat with continuous=0 -> IDLE, running=0.
REQ-039 snap_req in RUN with model counter 0x1234_5678 -> write (4,0), reads at 4 then 5; snap_valid 4 cycles after acceptance, snap_value=0x1234_5678, back to RUN.
REQ-040 Same-cycle tmr_irq, cfg_stop, snap_req in RUN -> CLR first; cfg_stop and snap_req dropped; cfg_start during WR_PH ignored.
REQ-041 tick_count=0xFFFF plus one irq -> 0x0000; assert reset during WR_PL -> outputs at reset values the same cycle, no WR_PH write.
